lfsr_spawn_gen: RTL and testbench

//   Parametrised Fibonacci-LFSR pseudo-random source with an obstacle/coin spawn scheduler.

---
 rtl/lfsr_spawn_gen.sv | 163 ++++++++++++++++
 tb/tb_lfsr_spawn_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_spawn_gen.sv
// lfsr_spawn_gen: Fibonacci LFSR driving a valid/ready obstacle/coin spawn scheduler.
// Optional LFSR_NO_REPEAT_LANE_EN: never offer the last accepted lane twice in a row.
module lfsr_spawn_gen #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] SEED         = 16'hACE1,
  parameter int               NUM_LANES    = 4,
  parameter int               LANE_W       = 2,
  parameter logic [8:0]       SPAWN_THRESH = 9'd96,
  parameter int               MIN_GAP      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic              tick_i,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic [WIDTH-1:0]  rnd_o,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [LANE_W-1:0] spawn_lane,
  output logic              spawn_kind,
  output logic [7:0]        missed_o
);

  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [LANE_W:0] NL = (LANE_W + 1)'(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  rnd_q, rnd_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              kind_q, kind_d;
  logic [7:0]        miss_q, miss_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic              fb;
  logic              hit;
  logic [LANE_W:0]   raw;
  logic [LANE_W:0]   fold;
  logic [LANE_W-1:0] pick;

  always_comb begin
    fb    = ^(rnd_q & TAPS);
    rnd_d = rnd_q;
    if (seed_load) begin
      rnd_d = (seed_in == '0) ? SEED : seed_in;
    end else if (step_en) begin
      rnd_d = {rnd_q[WIDTH-2:0], fb};
    end
  end

  always_comb begin
    hit  = ({1'b0, rnd_q[7:0]} < SPAWN_THRESH);
    raw  = {1'b0, rnd_q[WIDTH-1 -: LANE_W]};
    fold = (raw >= NL) ? (raw - NL) : raw;
  end

`ifdef LFSR_NO_REPEAT_LANE_EN
  logic [LANE_W-1:0] last_q, last_d;

  // Bump to the next lane (wrapping) when the draw repeats the last accepted one.
  always_comb begin
    pick = fold[LANE_W-1:0];
    if (pick == last_q) begin
      pick = (pick == LAST_LANE) ? '0 : pick + LANE_W'(1);
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == OFFER && spawn_ready) begin
      last_d = lane_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick = fold[LANE_W-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    kind_d  = kind_q;
    miss_d  = miss_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (tick_i && hit) begin
          lane_d  = pick;
          kind_d  = rnd_q[8];
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Acceptance wins over a coincident tick, so that tick is not a miss.
        if (spawn_ready) begin
          if (MIN_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GW'(MIN_GAP);
          end
        end else if (tick_i && miss_q != 8'hFF) begin
          miss_d = miss_q + 8'd1;
        end
      end
      GAP: begin
        if (tick_i) begin
          if (gap_q <= GW'(1)) begin
            state_d = IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= SEED;
      lane_q  <= '0;
      kind_q  <= 1'b0;
      miss_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      lane_q  <= lane_d;
      kind_q  <= kind_d;
      miss_q  <= miss_d;
      gap_q   <= gap_d;
    end
  end

  assign rnd_o       = rnd_q;
  assign spawn_valid = (state_q == OFFER);
  assign spawn_lane  = lane_q;
  assign spawn_kind  = kind_q;
  assign missed_o    = miss_q;

endmodule

// File: tb/tb_lfsr_spawn_gen.sv
// tb_lfsr_spawn_gen: directed scoreboard bench for lfsr_spawn_gen.
// Three instances cover default, gap/always-spawn and 3-lane configurations.
module tb_lfsr_spawn_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_en = 1'b0;
  logic        tick = 1'b0;
  logic        tick_l3 = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        ready = 1'b0;
  logic        rdy_l3 = 1'b0;

  logic [15:0] rnd_def, rnd_gap, rnd_l3;
  logic        v_def, v_gap, v_l3;
  logic [1:0]  ln_def, ln_gap, ln_l3;
  logic        k_def, k_gap, k_l3;
  logic [7:0]  m_def, m_gap, m_l3;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  logic [1:0]  last_l3 = 2'd0;
  logic [1:0]  exp_ln;
  logic        zero_seen = 1'b0;
  logic        early = 1'b0;

  always #5 clk = ~clk;

  lfsr_spawn_gen u_def (
    .clk(clk), .rst(rst), .step_en(step_en), .tick_i(tick),
    .seed_load(seed_load), .seed_in(seed_in), .rnd_o(rnd_def),
    .spawn_valid(v_def), .spawn_ready(ready), .spawn_lane(ln_def),
    .spawn_kind(k_def), .missed_o(m_def)
  );

  lfsr_spawn_gen #(.SPAWN_THRESH(9'd256), .MIN_GAP(3)) u_gap (
    .clk(clk), .rst(rst), .step_en(step_en), .tick_i(tick),
    .seed_load(seed_load), .seed_in(seed_in), .rnd_o(rnd_gap),
    .spawn_valid(v_gap), .spawn_ready(ready), .spawn_lane(ln_gap),
    .spawn_kind(k_gap), .missed_o(m_gap)
  );

  lfsr_spawn_gen #(.NUM_LANES(3), .SPAWN_THRESH(9'd256), .MIN_GAP(0)) u_l3 (
    .clk(clk), .rst(rst), .step_en(step_en), .tick_i(tick_l3),
    .seed_load(seed_load), .seed_in(seed_in), .rnd_o(rnd_l3),
    .spawn_valid(v_l3), .spawn_ready(rdy_l3), .spawn_lane(ln_l3),
    .spawn_kind(k_l3), .missed_o(m_l3)
  );

  function automatic logic [15:0] nx(logic [15:0] s);
    logic f;
    f = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], f};
  endfunction

  function automatic logic [1:0] map_lane(logic [15:0] r, int nl, logic [1:0] last);
    int raw;
    int l;
    raw = int'(r[15:14]);
    l = (raw >= nl) ? raw - nl : raw;
`ifdef LFSR_NO_REPEAT_LANE_EN
    if (l == int'(last)) l = (l + 1) % nl;
`else
    if (last == 2'd3 && nl < 0) l = 0;
`endif
    return 2'(l);
  endfunction

  task automatic push(logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(string tag, logic [31:0] obs);
    logic [31:0] exp;
    exp = 'x;
    if (sb.size() != 0) exp = sb.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seed(logic [15:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    step();
    seed_load = 1'b0;
  endtask

  task automatic spawn_l3(logic [15:0] s, string tag);
    seed(s);
    exp_ln  = map_lane(s, 3, last_l3);
    tick_l3 = 1'b1;
    step();
    tick_l3 = 1'b0;
    push(exp_ln);
    chk(tag, ln_l3);
    rdy_l3 = 1'b1;
    step();
    rdy_l3 = 1'b0;
    last_l3 = exp_ln;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    push(32'hACE1); chk("rst_rnd", rnd_def);
    push(0); chk("rst_valid", v_def);
    push(0); chk("rst_lane", ln_def);
    push(0); chk("rst_kind", k_def);
    push(0); chk("rst_missed", m_def);
    step();
    step();
    rst = 1'b0;

    step_en = 1'b1;
    push(32'h59C3);
    step();
    step_en = 1'b0;
    chk("lfsr_step", rnd_def);
    push(32'h59C3);
    step();
    chk("lfsr_hold", rnd_def);

    seed_load = 1'b1;
    seed_in   = 16'h0000;
    step_en   = 1'b1;
    push(32'hACE1);
    step();
    chk("seed_zero", rnd_def);
    seed_in = 16'h0001;
    push(32'h0001);
    step();
    chk("seed_one", rnd_def);
    seed_load = 1'b0;
    push(nx(16'h0001));
    step();
    chk("step_after_seed", rnd_def);
    step_en = 1'b0;

    seed(16'h0000);
    step_en = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      step();
      if (rnd_def == 16'h0000) zero_seen = 1'b1;
      if (i < 65534 && rnd_def == 16'hACE1) early = 1'b1;
    end
    step_en = 1'b0;
    push(32'hACE1); chk("period_wrap", rnd_def);
    push(0); chk("never_zero", zero_seen);
    push(0); chk("no_early_wrap", early);

    seed(16'h1260);
    tick = 1'b1;
    step();
    tick = 1'b0;
    push(0); chk("thresh_96_skip", v_def);
    seed(16'h125F);
    tick = 1'b1;
    step();
    tick = 1'b0;
    push(1); chk("thresh_95_spawn", v_def);
    push(map_lane(16'h125F, 4, 2'd0)); chk("def_lane", ln_def);
    push(0); chk("def_kind", k_def);

    rst = 1'b1;
    #1;
    push(0); chk("midrst_valid", v_def);
    push(0); chk("midrst_missed", m_gap);
    push(32'hACE1); chk("midrst_rnd", rnd_def);
    step();
    rst = 1'b0;

    seed(16'h4100);
    for (int i = 0; i < 10; i++) begin
      tick    = 1'b1;
      step_en = 1'b1;
      step();
      tick = 1'b0;
      if (i == 0) begin
        push(1); chk("offer_valid", v_gap);
      end
      step();
    end
    step_en = 1'b0;
    push(1); chk("stall_valid", v_gap);
    push(map_lane(16'h4100, 4, 2'd0)); chk("stall_lane", ln_gap);
    push(1); chk("stall_kind", k_gap);
    push(9); chk("stall_missed", m_gap);

    ready = 1'b1;
    step();
    ready = 1'b0;
    push(0); chk("accept_drop", v_gap);
    for (int k = 1; k <= 4; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      push((k == 4) ? 1 : 0);
      chk("gap_tick", v_gap);
      step();
    end

    ready = 1'b1;
    tick  = 1'b1;
    step();
    ready = 1'b0;
    tick  = 1'b0;
    push(0); chk("tick_ready_valid", v_gap);
    push(9); chk("tick_ready_nomiss", m_gap);

    for (int k = 0; k < 4; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    push(1); chk("reoffer_valid", v_gap);
    tick = 1'b1;
    repeat (245) step();
    tick = 1'b0;
    push(254); chk("missed_254", m_gap);
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    push(255); chk("missed_sat", m_gap);

    spawn_l3(16'hC000, "l3_raw3");
    spawn_l3(16'h8000, "l3_raw2");
    spawn_l3(16'h4000, "l3_lane1_a");
    spawn_l3(16'h4000, "l3_lane1_b");
    push(0); chk("l3_idle", v_l3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
